// File: rtl/frame_pkg.sv
// Shared definitions for the frame packer.
// Holds the FSM state encoding and the default header sync byte.
package frame_pkg;

  typedef enum logic [1:0] {
    S_HDR = 2'd0,  // emit header {sync, seq}
    S_PAY = 2'd1,  // pass payload words through
    S_SUM = 2'd2   // emit two's-complement checksum
  } state_t;

  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

endpackage

// File: rtl/frame_out_slot.sv
// Single-entry output register for the frame packer.
// Ports:
//   clk, rst      - clock, asynchronous active-high reset
//   load          - capture load_data/load_last this cycle (only when slot_free)
//   load_data     - word to place in the slot
//   load_last     - word is the frame checksum
//   output_enable - downstream accepts the slot contents this cycle
//   output_valid  - slot holds a word
//   data_out      - slot word
//   frame_last    - slot word is the checksum
//   slot_free     - slot can take a new word at the next edge
module frame_out_slot (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] load_data,
  input  logic        load_last,
  input  logic        output_enable,
  output logic        output_valid,
  output logic [15:0] data_out,
  output logic        frame_last,
  output logic        slot_free
);

  // The slot may be refilled on the same edge its word is taken downstream,
  // which keeps the stream bubble-free.
  assign slot_free = !output_valid || output_enable;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      output_valid <= 1'b0;
      data_out     <= 16'h0000;
      frame_last   <= 1'b0;
    end else if (load) begin
      output_valid <= 1'b1;
      data_out     <= load_data;
      frame_last   <= load_last;
    end else if (output_enable) begin
      // Drained with nothing to replace it: data_out keeps its old value.
      output_valid <= 1'b0;
      frame_last   <= 1'b0;
    end
  end

endmodule

// File: rtl/frame_packer.sv
// Frame packer: wraps a stream of 16-bit payload words into frames of
//   header {SYNC, seq}, PAYLOAD_WORDS payload words, checksum.
// The checksum makes the 16-bit sum of all frame words equal zero.
// Handshake: on either side a word moves at a rising clk edge where the
// valid and enable of that side are both high; the two sides are independent.
// Ports:
//   clk, rst      - clock, asynchronous active-high reset
//   input_valid   - upstream word available on data_in
//   input_enable  - packer accepts data_in this cycle
//   data_in       - payload word
//   output_valid  - data_out holds a frame word
//   output_enable - downstream accepts data_out this cycle
//   data_out      - frame word
//   frame_last    - data_out is the checksum word
module frame_packer
  import frame_pkg::*;
#(
  parameter int          PAYLOAD_WORDS = 4,
  parameter logic [7:0]  SYNC          = SYNC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        input_valid,
  output logic        input_enable,
  input  logic [15:0] data_in,
  output logic        output_valid,
  input  logic        output_enable,
  output logic [15:0] data_out,
  output logic        frame_last
);

  localparam logic [7:0] LAST_IDX = 8'(PAYLOAD_WORDS - 1);

  state_t      state, state_next;
  logic [7:0]  seq;
  logic [7:0]  cnt;
  logic [15:0] sum;
  logic        slot_free;
  logic        load;
  logic        load_last;
  logic [15:0] load_data;
  logic        in_xfer;

  assign in_xfer = input_valid && input_enable;

  frame_out_slot u_slot (
    .clk           (clk),
    .rst           (rst),
    .load          (load),
    .load_data     (load_data),
    .load_last     (load_last),
    .output_enable (output_enable),
    .output_valid  (output_valid),
    .data_out      (data_out),
    .frame_last    (frame_last),
    .slot_free     (slot_free)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_HDR;
    else     state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_HDR:   if (slot_free) state_next = S_PAY;
      S_PAY:   if (in_xfer && (cnt == LAST_IDX)) state_next = S_SUM;
      S_SUM:   if (slot_free) state_next = S_HDR;
      default: state_next = S_HDR;
    endcase
  end

  // Output logic: what goes into the slot this cycle
  always_comb begin
    input_enable = 1'b0;
    load         = 1'b0;
    load_data    = 16'h0000;
    load_last    = 1'b0;
    case (state)
      S_HDR: begin
        load      = slot_free;
        load_data = {SYNC, seq};
      end
      S_PAY: begin
        // Combinational from output_enable so a stalled slot blocks input
        // while a draining slot accepts in the same cycle.
        input_enable = slot_free;
        load         = in_xfer;
        load_data    = data_in;
      end
      S_SUM: begin
        load      = slot_free;
        load_data = 16'h0000 - sum;
        load_last = 1'b1;
      end
      default: ;
    endcase
  end

  // Frame bookkeeping: sequence number, running sum, payload count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seq <= 8'h00;
      sum <= 16'h0000;
      cnt <= 8'h00;
    end else begin
      case (state)
        S_HDR: if (slot_free) begin
          sum <= {SYNC, seq};
          cnt <= 8'h00;
        end
        S_PAY: if (in_xfer) begin
          sum <= sum + data_in;
          cnt <= cnt + 8'h01;
        end
        S_SUM: if (slot_free) seq <= seq + 8'h01;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_packer.sv
// Directed bench for frame_packer (default instance plus a one-word-payload
// instance). Expected frames are built by the bench from the payload words.
module tb_frame_packer;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst, rst1;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT: default parameters ----------------
  logic        input_valid, input_enable, output_valid, output_enable, frame_last;
  logic [15:0] data_in, data_out;

  frame_packer u_dut (
    .clk           (clk),
    .rst           (rst),
    .input_valid   (input_valid),
    .input_enable  (input_enable),
    .data_in       (data_in),
    .output_valid  (output_valid),
    .output_enable (output_enable),
    .data_out      (data_out),
    .frame_last    (frame_last)
  );

  // ---------------- DUT: one payload word ----------------
  logic        input_valid1, input_enable1, output_valid1, output_enable1, frame_last1;
  logic [15:0] data_in1, data_out1;

  frame_packer #(.PAYLOAD_WORDS(1)) u_dut1 (
    .clk           (clk),
    .rst           (rst1),
    .input_valid   (input_valid1),
    .input_enable  (input_enable1),
    .data_in       (data_in1),
    .output_valid  (output_valid1),
    .output_enable (output_enable1),
    .data_out      (data_out1),
    .frame_last    (frame_last1)
  );

  // ---------------- scoreboard state ----------------
  logic [16:0] exp_q[$];   // {frame_last, word}
  logic [15:0] in_q[$];    // payload words still to send
  int          n_cmp, n_err;
  logic        iv_gate, toggle_mode;
  logic [15:0] acc;
  int          pos;
  logic [7:0]  prev_hdr;
  logic        saw_wrap, gap_seen;
  int          k;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic push_frame(input logic [7:0] seq, input logic [15:0] seed,
                            input logic [15:0] step, input int n_send);
    logic [15:0] s, w;
    s = {8'hA5, seq};
    exp_q.push_back({1'b0, s});
    w = seed;
    for (int i = 0; i < n_send; i++) begin
      exp_q.push_back({1'b0, w});
      in_q.push_back(w);
      s = s + w;
      w = w + step;
    end
    if (n_send == 4) exp_q.push_back({1'b1, 16'h0000 - s});
  endtask

  task automatic update_inputs();
    if (toggle_mode) iv_gate = ~iv_gate;
    input_valid = iv_gate && (in_q.size() > 0);
    if (in_q.size() > 0) data_in = in_q[0];
    else                 data_in = 16'h0000;
  endtask

  // One clock: sample handshakes mid-cycle, retire transfers after the edge.
  task automatic tick();
    logic        c_ov, c_oe, c_fl, c_ie, c_iv;
    logic [15:0] c_d;
    logic [16:0] e;
    @(negedge clk);
    c_ov = output_valid; c_oe = output_enable; c_fl = frame_last;
    c_ie = input_enable; c_iv = input_valid;   c_d  = data_out;
    @(posedge clk);
    #1;
    if (c_ie && c_iv && (in_q.size() > 0)) void'(in_q.pop_front());
    if (!c_ov) gap_seen = 1'b1;
    if (c_ov && c_oe) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $error("FAIL sb_underflow: observed %0h expected none", c_d);
      end else begin
        e = exp_q.pop_front();
        check("sb_word", {15'b0, c_fl, c_d}, {15'b0, e});
      end
      if (pos == 0) begin
        if (prev_hdr == 8'hFF && c_d[7:0] == 8'h00) saw_wrap = 1'b1;
        prev_hdr = c_d[7:0];
      end
      acc = acc + c_d;
      pos++;
      if (c_fl) begin
        check("frame_sum", {16'h0, acc}, 32'h0);
        acc = 16'h0000;
        pos = 0;
      end
    end
    update_inputs();
    #1;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      tick();
      n++;
    end
    check("drain_left", exp_q.size(), 0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    n_cmp = 0; n_err = 0;
    iv_gate = 1'b1; toggle_mode = 1'b0;
    acc = 16'h0000; pos = 0; prev_hdr = 8'h00;
    saw_wrap = 1'b0; gap_seen = 1'b0;
    rst = 1'b1; rst1 = 1'b1;
    input_valid = 1'b0; data_in = 16'h0000; output_enable = 1'b0;
    input_valid1 = 1'b0; data_in1 = 16'h0000; output_enable1 = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_ov", output_valid, 0);
    check("rst_dout", data_out, 16'h0000);
    check("rst_last", frame_last, 0);
    check("rst_ie", input_enable, 0);
    check("rst1_ov", output_valid1, 0);
    check("rst1_ie", input_enable1, 0);

    // Basic frame 1,2,3,4 -> A500 0001 0002 0003 0004 5AF6, back to back
    push_frame(8'h00, 16'h0001, 16'h0001, 4);
    output_enable = 1'b1;
    update_inputs();
    rst = 1'b0;
    tick();
    check("a_hdr", data_out, 16'hA500);
    check("a_hdr_ov", output_valid, 1);
    check("a_hdr_last", frame_last, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("a_word", data_out, (i < 4) ? 32'(i + 1) : 32'h5AF6);
      check("a_ov", output_valid, 1);
      check("a_last", frame_last, (i == 4) ? 1 : 0);
    end

    // Downstream stall mid-payload
    push_frame(8'h01, 16'h1111, 16'h1111, 4);
    update_inputs();
    k = 0;
    while (!(output_valid && data_out == 16'h2222) && k < 20) begin
      tick();
      k++;
    end
    check("b_reach", data_out, 16'h2222);
    output_enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("b_stall_dout", data_out, 16'h2222);
      check("b_stall_ov", output_valid, 1);
      check("b_stall_ie", input_enable, 0);
      check("b_stall_last", frame_last, 0);
    end
    output_enable = 1'b1;
    drain(40);

    // Upstream valid toggling every cycle
    push_frame(8'h02, 16'hBEEF, 16'h4213, 4);
    gap_seen = 1'b0;
    toggle_mode = 1'b1;
    update_inputs();
    drain(60);
    check("c_gap", gap_seen, 1);
    toggle_mode = 1'b0;
    iv_gate = 1'b1;

    // 257 frames: sequence wraps FF -> 00, every frame sums to zero
    for (int f = 0; f < 257; f++)
      push_frame(8'(3 + f), 16'(f) * 16'h9E37, 16'h7F4B, 4);
    update_inputs();
    drain(1700);
    check("d_wrap", saw_wrap, 1);

    // Reset after two payload words of frame seq 04
    push_frame(8'h04, 16'h0AAA, 16'h0111, 2);
    update_inputs();
    k = 0;
    while (!(output_valid && data_out == 16'h0BBB) && k < 20) begin
      tick();
      k++;
    end
    check("e_reach", data_out, 16'h0BBB);
    rst = 1'b1;
    #1;
    check("e_rst_ov", output_valid, 0);
    check("e_rst_dout", data_out, 16'h0000);
    check("e_rst_last", frame_last, 0);
    check("e_rst_ie", input_enable, 0);
    exp_q.delete();
    in_q.delete();
    acc = 16'h0000;
    pos = 0;
    update_inputs();
    @(posedge clk);
    #1;
    check("e_hold_ov", output_valid, 0);
    push_frame(8'h00, 16'h1000, 16'h0001, 4);
    update_inputs();
    rst = 1'b0;
    tick();
    check("e_hdr", data_out, 16'hA500);
    check("e_hdr_ov", output_valid, 1);
    drain(20);

    // PAYLOAD_WORDS = 1 with FFFF -> A500 FFFF 5B01
    rst1 = 1'b0;
    output_enable1 = 1'b1;
    input_valid1 = 1'b1;
    data_in1 = 16'hFFFF;
    @(posedge clk);
    #1;
    check("f_hdr", data_out1, 16'hA500);
    check("f_hdr_ov", output_valid1, 1);
    @(posedge clk);
    #1;
    input_valid1 = 1'b0;
    check("f_pay", data_out1, 16'hFFFF);
    check("f_pay_last", frame_last1, 0);
    @(posedge clk);
    #1;
    check("f_sum", data_out1, 16'h5B01);
    check("f_sum_last", frame_last1, 1);
    check("f_sum_ie", input_enable1, 0);
    @(posedge clk);
    #1;
    check("f_hdr2", data_out1, 16'hA501);
    check("f_hdr2_last", frame_last1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
